// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - default widths and word/address types for the 2R1W RAM
package ram_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 8;

  typedef logic [DATA_W_DEF-1:0] word_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/ram_rd_port.sv
// rtl/ram_rd_port.sv - registered read port with write-first forwarding
module ram_rd_port
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] mem_word,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr_wr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data
);

  logic fwd;

  // A write to the address being read this edge wins over the stored word
  assign fwd = we && (addr_wr == addr);

  // Output register: cleared asynchronously, loads once per rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else begin
      data <= fwd ? data_in : mem_word;
    end
  end

endmodule

// File: rtl/ram_2r1w.sv
// rtl/ram_2r1w.sv - flop-array memory with two registered read ports and one write port
module ram_2r1w
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [ADDR_W-1:0] addr_wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              we,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  // Plain flops so the whole array can be cleared by the async reset
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_b;

  // Storage: cleared on reset, otherwise one word written per enabled edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr_wr] <= data_in;
    end
  end

  assign mem_a = mem[addr_a];
  assign mem_b = mem[addr_b];

  ram_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr_a),
    .mem_word (mem_a),
    .we       (we),
    .addr_wr  (addr_wr),
    .data_in  (data_in),
    .data     (data_a)
  );

  ram_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr_b),
    .mem_word (mem_b),
    .we       (we),
    .addr_wr  (addr_wr),
    .data_in  (data_in),
    .data     (data_b)
  );

endmodule

// File: tb/tb_ram_2r1w.sv
// tb/tb_ram_2r1w.sv - directed and model-checked bench for ram_2r1w
module tb_ram_2r1w;

  logic        clk;
  logic        rst_n;
  logic [7:0]  addr_a;
  logic [7:0]  addr_b;
  logic [7:0]  addr_wr;
  logic [31:0] data_in;
  logic        we;
  logic [31:0] data_a;
  logic [31:0] data_b;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] model [256];
  logic [31:0] exp_a;
  logic [31:0] exp_b;

  ram_2r1w dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr_a  (addr_a),
    .addr_b  (addr_b),
    .addr_wr (addr_wr),
    .data_in (data_in),
    .we      (we),
    .data_a  (data_a),
    .data_b  (data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    we      = 1'b0;
    addr_a  = 8'd0;
    addr_b  = 8'd1;
    addr_wr = 8'd0;
    data_in = 32'h0;
    #2;
    check("reset_a", data_a, 32'h0);
    check("reset_b", data_b, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // read 0 and 1 after reset
    tick();
    check("post_rst_a0", data_a, 32'h0);
    check("post_rst_b1", data_b, 32'h0);

    // write A5A5A5A5 to address 1 while reading address 0
    we = 1'b1; addr_wr = 8'd1; data_in = 32'hA5A5A5A5;
    addr_a = 8'd0; addr_b = 8'd0;
    tick();
    check("wr1_rd0_a", data_a, 32'h0);
    we = 1'b0; addr_a = 8'd1; addr_b = 8'd1;
    tick();
    check("rd1_a", data_a, 32'hA5A5A5A5);
    check("rd1_b", data_b, 32'hA5A5A5A5);
    addr_a = 8'd0;
    #2;
    check("hold_a", data_a, 32'hA5A5A5A5);
    tick();
    check("rd0_a", data_a, 32'h0);
    check("rd1_b_again", data_b, 32'hA5A5A5A5);

    // write DEADBEEF to address 0
    we = 1'b1; addr_wr = 8'd0; data_in = 32'hDEADBEEF;
    tick();
    we = 1'b0; addr_a = 8'd0; addr_b = 8'd0;
    tick();
    check("rd0_dead_a", data_a, 32'hDEADBEEF);
    check("rd0_dead_b", data_b, 32'hDEADBEEF);
    addr_a = 8'd1;
    tick();
    check("rd1_keep_a", data_a, 32'hA5A5A5A5);

    // forwarding: write 5 while port A reads 5, port B reads 1
    we = 1'b1; addr_wr = 8'd5; data_in = 32'h12345678;
    addr_a = 8'd5; addr_b = 8'd1;
    tick();
    check("fwd_a", data_a, 32'h12345678);
    check("nofwd_b", data_b, 32'hA5A5A5A5);
    we = 1'b0; addr_b = 8'd5;
    tick();
    check("rd5_b", data_b, 32'h12345678);

    // we pulse strictly between edges must not write
    addr_wr = 8'd5; data_in = 32'hCAFEF00D; addr_a = 8'd5;
    #1 we = 1'b1;
    #2 we = 1'b0;
    tick();
    tick();
    check("we_glitch_a", data_a, 32'h12345678);

    // boundary address 255, both ports same address with forwarding
    we = 1'b1; addr_wr = 8'd255; data_in = 32'h0BADCAFE;
    addr_a = 8'd255; addr_b = 8'd255;
    tick();
    check("fwd255_a", data_a, 32'h0BADCAFE);
    check("fwd255_b", data_b, 32'h0BADCAFE);
    we = 1'b0;
    tick();
    check("rd255_a", data_a, 32'h0BADCAFE);

    // reset asserted mid-write, between edges
    addr_a = 8'd0; addr_b = 8'd1;
    tick();
    we = 1'b1; addr_wr = 8'd0; data_in = 32'hFFFFFFFF;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_a", data_a, 32'h0);
    check("async_rst_b", data_b, 32'h0);
    tick();
    check("rst_hold_a", data_a, 32'h0);
    we = 1'b0;
    rst_n = 1'b1;
    addr_a = 8'd0; addr_b = 8'd1;
    tick();
    check("rst_rd0", data_a, 32'h0);
    check("rst_rd1", data_b, 32'h0);
    addr_a = 8'd5; addr_b = 8'd255;
    tick();
    check("rst_rd5", data_a, 32'h0);
    check("rst_rd255", data_b, 32'h0);

    // random traffic against a reference model
    for (int i = 0; i < 256; i++) model[i] = 32'h0;
    exp_a = data_a;
    exp_b = data_b;
    for (int n = 0; n < 600; n++) begin
      we      = ($urandom_range(0, 1) == 1);
      addr_wr = 8'($urandom_range(0, 255));
      data_in = $urandom;
      addr_a  = (n % 5 == 0) ? addr_wr : 8'($urandom_range(0, 255));
      addr_b  = (n % 7 == 0) ? addr_a  : 8'($urandom_range(0, 255));
      #2;
      check("rand_hold_a", data_a, exp_a);
      check("rand_hold_b", data_b, exp_b);
      exp_a = (we && addr_wr == addr_a) ? data_in : model[addr_a];
      exp_b = (we && addr_wr == addr_b) ? data_in : model[addr_b];
      if (we) model[addr_wr] = data_in;
      tick();
      check("rand_a", data_a, exp_a);
      check("rand_b", data_b, exp_b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_2r1w.md
RAM_2R1W -- requirements
Module: ram_2r1w

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits SHALL be configurable.
REQ-002 Parameter ADDR_W, default 8, address width SHALL be configurable; depth SHALL be 2**ADDR_W (256 words by default).
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port addr_a, input, ADDR_W bits: read port A address.
REQ-006 Port addr_b, input, ADDR_W bits: read port B address.
REQ-007 Port addr_wr, input, ADDR_W bits: write port address.
REQ-008 Port data_in, input, DATA_W bits: write data.
REQ-009 Port we, input, 1 bit: write enable, active high.
REQ-010 Port data_a, output, DATA_W bits: registered read data, port A.
REQ-011 Port data_b, output, DATA_W bits: registered read data, port B.

Function
REQ-012 The block SHALL be a 2-read, 1-write memory, with all three ports usable in the same cycle.
REQ-013 Write: on a rising clk edge with we=1, mem[addr_wr] SHALL take data_in; with we=0, memory SHALL be unchanged.
REQ-014 Read: on every rising clk edge, data_a SHALL load mem[addr_a] and data_b SHALL load mem[addr_b]; latency is 1 cycle from the address to the output.
REQ-015 Outputs SHALL hold their value between edges and SHALL NOT change combinationally with an address change.
REQ-016 Read-during-write, same address: when we=1 and addr_wr equals addr_a (or addr_b) at the same edge, that port SHALL output data_in (write-first forwarding).
REQ-017 Read-during-write, different address: read ports SHALL return the stored contents, unaffected by the write.
REQ-018 addr_a equal to addr_b SHALL give identical data on both ports.
REQ-019 Every address 0 to 2**ADDR_W-1 SHALL be valid; no wrap or out-of-range case exists.
REQ-020 we SHALL be sampled only at the clock edge; a pulse between edges SHALL have no effect.

Reset
REQ-021 While rst_n=0, all memory words, data_a and data_b SHALL be 0, regardless of clk.
REQ-022 Reset SHALL take effect asynchronously on the falling edge of rst_n, including during a write cycle; that write SHALL be discarded.
REQ-023 Reset release SHALL be synchronous to the design; the first write or read SHALL occur at the first rising clk edge after rst_n=1.

Structure
REQ-024 Package ram_pkg SHALL hold the DATA_W and ADDR_W default constants and the word and address types.
REQ-025 Sub-module ram_rd_port SHALL be instantiated once per read port; it implements the registered read, write-first forwarding and reset of its output.
REQ-026 Memory SHALL be a flop array to support the asynchronous clear; no vendor RAM primitives SHALL be used.

Verification
REQ-027 Apply reset, then read addresses 0 and 1 -> data_a=data_b=32'h00000000.
REQ-028 Write 32'hA5A5A5A5 to address 1; next cycle set addr_a=addr_b=1 -> both outputs 32'hA5A5A5A5 one edge later; address 0 still reads 0.
REQ-029 Write 32'hDEADBEEF to address 0 -> addr_a=addr_b=0 reads 32'hDEADBEEF; address 1 still reads 32'hA5A5A5A5.
REQ-030 Write 32'h12345678 to address 5 while addr_a=5 and addr_b=1 in the same cycle -> data_a=32'h12345678 (forwarded) and data_b=32'hA5A5A5A5.
REQ-031 Assert rst_n=0 mid-write between clock edges -> outputs go to 0 immediately; after release, addresses 0, 1 and 5 read 0.
REQ-032 Random writes and reads on both ports against a reference model over all 256 addresses -> zero mismatches, with the 1-cycle latency checked.
